// File: rtl/in_port_pkg.sv
// Shared definitions for the IN-instruction input peripheral.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package in_port_pkg;

    // Width of the core data path that data_In feeds.
    localparam int WORD_W = 32;

    // FSM encoding. The values are fixed so that state dumps read the same
    // in every build.
    localparam logic [2:0] IDLE_ENC         = 3'd0;
    localparam logic [2:0] WAIT_RELEASE_ENC = 3'd1;
    localparam logic [2:0] WAIT_PRESS_ENC   = 3'd2;
    localparam logic [2:0] CAPTURE_ENC      = 3'd3;
    localparam logic [2:0] DONE_ENC         = 3'd4;

    typedef enum logic [2:0] {
        IDLE         = IDLE_ENC,
        WAIT_RELEASE = WAIT_RELEASE_ENC,
        WAIT_PRESS   = WAIT_PRESS_ENC,
        CAPTURE      = CAPTURE_ENC,
        DONE         = DONE_ENC
    } in_state_t;

    // True while the peripheral is waiting on the operator's button.
    function automatic logic is_waiting(input in_state_t st);
        return (st == WAIT_RELEASE) || (st == WAIT_PRESS);
    endfunction

endpackage

// File: rtl/in_debounce.sv
// Synchronises the raw confirm button and debounces it into a stable level.
// Latency: SYNC_STAGES cycles of synchronisation plus DEBOUNCE_CYCLES of stable level.
// Backpressure: none; this block runs freely every cycle regardless of the FSM.
//
// Ports:
//   clock       system clock, all state on posedge
//   flag_Reset  asynchronous active-low reset
//   button      raw, bouncy, asynchronous push button (active-high)
//   btn_db      debounced button level
module in_debounce #(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic clock,
    input  logic flag_Reset,
    input  logic button,
    output logic btn_db
);

    // A one-cycle debounce still needs a 1-bit counter to keep the logic uniform.
    localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [SYNC_STAGES-1:0] btn_sync;
    logic                   btn_s;
    logic [CNT_W-1:0]       cnt;

    // Plain shift-register synchroniser; bit 0 is the metastability-exposed stage.
    always_ff @(posedge clock or negedge flag_Reset) begin
        if (!flag_Reset) begin
            btn_sync <= '0;
        end else begin
            btn_sync <= {btn_sync[SYNC_STAGES-2:0], button};
        end
    end

    assign btn_s = btn_sync[SYNC_STAGES-1];

    // The counter measures how long btn_s has disagreed with the accepted
    // level. Any agreement restarts the measurement, so a bounce shorter than
    // DEBOUNCE_CYCLES never reaches btn_db.
    always_ff @(posedge clock or negedge flag_Reset) begin
        if (!flag_Reset) begin
            cnt    <= '0;
            btn_db <= 1'b0;
        end else if (btn_s == btn_db) begin
            cnt <= '0;
        end else if (cnt == CNT_LAST) begin
            btn_db <= btn_s;
            cnt    <= '0;
        end else begin
            cnt <= cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/in_port.sv
// IN-instruction peripheral: stalls the core until the operator confirms, then captures the switches.
// Latency: 3 cycles plus the debounced-press time from flag_In to the in_Ready pulse.
// Backpressure: holds stall high while waiting; no capture happens until a fresh release+press.
//
// Ports:
//   clock           system clock, all state on posedge
//   flag_Reset      asynchronous active-low reset
//   flag_In         IN instruction in execute (level, held while stall=1)
//   sign_Extend     1: sign-extend switches, 0: zero-extend
//   switches        raw asynchronous board switches
//   confirm_Button  raw active-high push button
//   data_In         last captured value, extended to 32 bits
//   in_Ready        one-cycle pulse, data_In updated this cycle
//   stall           freezes PC / register write while an IN is pending
//   waiting_Led     lit while waiting on the operator
module in_port
    import in_port_pkg::*;
#(
    parameter int DATA_W          = 16,
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int SYNC_STAGES     = 2
) (
    input  logic              clock,
    input  logic              flag_Reset,
    input  logic              flag_In,
    input  logic              sign_Extend,
    input  logic [DATA_W-1:0] switches,
    input  logic              confirm_Button,
    output logic [WORD_W-1:0] data_In,
    output logic              in_Ready,
    output logic              stall,
    output logic              waiting_Led
);

    in_state_t         state;
    logic              btn_db;
    logic [DATA_W-1:0] sw_sync [SYNC_STAGES];
    logic [DATA_W-1:0] sw_s;
    logic [WORD_W-1:0] sw_ext;

    in_debounce #(
        .SYNC_STAGES     (SYNC_STAGES),
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_debounce (
        .clock      (clock),
        .flag_Reset (flag_Reset),
        .button     (confirm_Button),
        .btn_db     (btn_db)
    );

    // Switches are only synchronised, not debounced: the operator sets them
    // well before pressing confirm, so they are static when sampled.
    always_ff @(posedge clock or negedge flag_Reset) begin
        if (!flag_Reset) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                sw_sync[i] <= '0;
            end
        end else begin
            sw_sync[0] <= switches;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                sw_sync[i] <= sw_sync[i-1];
            end
        end
    end

    assign sw_s = sw_sync[SYNC_STAGES-1];

    // Word extension of the synchronised switches.
    generate
        if (DATA_W >= WORD_W) begin : g_full_width
            assign sw_ext = sw_s[WORD_W-1:0];
        end else begin : g_extend
            assign sw_ext = sign_Extend ? {{(WORD_W-DATA_W){sw_s[DATA_W-1]}}, sw_s}
                                        : {{(WORD_W-DATA_W){1'b0}}, sw_s};
        end
    endgenerate

    // Control FSM. in_Ready and data_In are both set on the edge that enters
    // DONE, so the core sees a fresh value in the same cycle stall drops.
    always_ff @(posedge clock or negedge flag_Reset) begin
        if (!flag_Reset) begin
            state    <= IDLE;
            data_In  <= '0;
            in_Ready <= 1'b0;
        end else begin
            in_Ready <= 1'b0;
            case (state)
                IDLE: begin
                    if (flag_In) begin
                        state <= WAIT_RELEASE;
                    end
                end
                // Require a released button first so that a button still held
                // from the previous IN cannot confirm this one.
                WAIT_RELEASE: begin
                    if (!flag_In) begin
                        state <= IDLE;
                    end else if (!btn_db) begin
                        state <= WAIT_PRESS;
                    end
                end
                WAIT_PRESS: begin
                    if (!flag_In) begin
                        state <= IDLE;
                    end else if (btn_db) begin
                        state <= CAPTURE;
                    end
                end
                CAPTURE: begin
                    data_In  <= sw_ext;
                    in_Ready <= 1'b1;
                    state    <= DONE;
                end
                DONE: begin
                    // A still-high flag_In here is the next IN; IDLE restarts it.
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Stall is combinational so the very first IN cycle already freezes the
    // core; it drops in DONE so the IN retires and writes data_In.
    assign stall = ((state == IDLE) && flag_In)
                 || (state == WAIT_RELEASE)
                 || (state == WAIT_PRESS)
                 || (state == CAPTURE);

    assign waiting_Led = is_waiting(state);

endmodule

// File: tb/tb_in_port.sv
// Self-checking bench for in_port: vector table of IN transactions plus corner-case sequences.
// Latency: n/a.
// Backpressure: n/a.
module tb_in_port;

    localparam int DW = 8;

    logic          clock;
    logic          flag_Reset;
    logic          flag_In;
    logic          sign_Extend;
    logic [DW-1:0] switches;
    logic          confirm_Button;
    logic [31:0]   data_In;
    logic          in_Ready;
    logic          stall;
    logic          waiting_Led;

    int errors = 0;
    int checks = 0;
    int pulses = 0;
    logic [31:0] exp_q[$];

    typedef struct {
        logic [DW-1:0] sw;
        logic          sign;
        logic [31:0]   expv;
    } vec_t;

    vec_t vecs[6];

    in_port #(
        .DATA_W          (DW),
        .DEBOUNCE_CYCLES (4),
        .SYNC_STAGES     (2)
    ) dut (
        .clock          (clock),
        .flag_Reset     (flag_Reset),
        .flag_In        (flag_In),
        .sign_Extend    (sign_Extend),
        .switches       (switches),
        .confirm_Button (confirm_Button),
        .data_In        (data_In),
        .in_Ready       (in_Ready),
        .stall          (stall),
        .waiting_Led    (waiting_Led)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, expv);
        end
    endtask

    // One clock; outputs sampled 1ns after the edge. Every in_Ready pulse is
    // matched against the scoreboard here.
    task automatic tick();
        @(posedge clock);
        #1;
        if (in_Ready === 1'b1) begin
            pulses++;
            check("stall_in_done", {31'd0, stall}, 32'd0);
            if (exp_q.size() == 0)
                check("unexpected_in_ready", {31'd0, in_Ready}, 32'd0);
            else
                check("scoreboard_data", data_In, exp_q.pop_front());
        end
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    // Waits for in_Ready with a cycle budget; stall must stay high until then.
    task automatic wait_ready(input int budget, output int n);
        logic seen;
        seen = 1'b0;
        n = 0;
        while (!seen && n < budget) begin
            tick();
            n++;
            if (in_Ready === 1'b1) seen = 1'b1;
            else check("stall_while_pending", {31'd0, stall}, 32'd1);
        end
        if (!seen) begin
            checks++;
            errors++;
            $display("FAIL wait_ready: no in_Ready within %0d cycles, required one pulse", budget);
        end
    endtask

    // Full IN transaction with a clean press; button is debounced-released on entry and exit.
    task automatic do_in(input logic [DW-1:0] sw, input logic sign, input logic [31:0] expv);
        int n;
        switches    = sw;
        sign_Extend = sign;
        flag_In     = 1'b1;
        #1;
        check("stall_on_flag_in", {31'd0, stall}, 32'd1);
        exp_q.push_back(expv);
        confirm_Button = 1'b1;
        wait_ready(40, n);
        flag_In        = 1'b0;
        confirm_Button = 1'b0;
        tick();
        check("ready_one_cycle", {31'd0, in_Ready}, 32'd0);
        check("data_held", data_In, expv);
        ticks(8);
    endtask

    initial begin
        int n;
        int p0;

        vecs[0] = '{8'hA5, 1'b1, 32'hFFFFFFA5};
        vecs[1] = '{8'hA5, 1'b0, 32'h000000A5};
        vecs[2] = '{8'h7F, 1'b1, 32'h0000007F};
        vecs[3] = '{8'h80, 1'b1, 32'hFFFFFF80};
        vecs[4] = '{8'h00, 1'b1, 32'h00000000};
        vecs[5] = '{8'hFF, 1'b0, 32'h000000FF};

        flag_Reset     = 1'b0;
        flag_In        = 1'b0;
        sign_Extend    = 1'b0;
        switches       = '0;
        confirm_Button = 1'b0;
        repeat (3) @(posedge clock);
        #1 flag_Reset = 1'b1;
        ticks(3);

        // Reset asserted between edges takes effect immediately.
        @(posedge clock);
        #4 flag_Reset = 1'b0;
        #1;
        check("rst_data", data_In, 32'h0);
        check("rst_ready", {31'd0, in_Ready}, 32'd0);
        check("rst_stall_noflag", {31'd0, stall}, 32'd0);
        flag_In = 1'b1;
        #1;
        check("rst_stall_flag", {31'd0, stall}, 32'd1);
        flag_In = 1'b0;
        tick();
        flag_Reset = 1'b1;
        ticks(3);

        // Table of clean transactions.
        for (int i = 0; i < 6; i++) begin
            do_in(vecs[i].sw, vecs[i].sign, vecs[i].expv);
        end

        // Bouncy button: period-4 toggling never survives the 4-cycle filter.
        switches    = 8'h96;
        sign_Extend = 1'b1;
        flag_In     = 1'b1;
        exp_q.push_back(32'hFFFFFF96);
        p0 = pulses;
        for (int i = 0; i < 10; i++) begin
            confirm_Button = (i % 2 == 0);
            ticks(2);
        end
        check("bounce_no_ready", pulses, p0);
        confirm_Button = 1'b1;
        wait_ready(40, n);
        check("bounce_latency_ge6", {31'd0, (n >= 6)}, 32'd1);
        check("bounce_one_capture", pulses, p0 + 1);
        flag_In        = 1'b0;
        confirm_Button = 1'b0;
        ticks(8);
        check("bounce_no_extra", pulses, p0 + 1);

        // Back-to-back IN with the button still held.
        switches    = 8'h5A;
        sign_Extend = 1'b1;
        flag_In     = 1'b1;
        exp_q.push_back(32'h0000005A);
        confirm_Button = 1'b1;
        wait_ready(40, n);
        p0 = pulses;
        tick();
        check("b2b_stall_idle", {31'd0, stall}, 32'd1);
        ticks(8);
        check("b2b_stall_held", {31'd0, stall}, 32'd1);
        check("b2b_led_held", {31'd0, waiting_Led}, 32'd1);
        check("b2b_no_ready", pulses, p0);
        switches    = 8'h3C;
        sign_Extend = 1'b0;
        exp_q.push_back(32'h0000003C);
        confirm_Button = 1'b0;
        ticks(8);
        check("b2b_led_press", {31'd0, waiting_Led}, 32'd1);
        confirm_Button = 1'b1;
        wait_ready(40, n);
        check("b2b_data", data_In, 32'h0000003C);
        flag_In        = 1'b0;
        confirm_Button = 1'b0;
        ticks(8);

        // Abort in WAIT_PRESS.
        switches = 8'h11;
        flag_In  = 1'b1;
        ticks(3);
        check("abort_led_wait", {31'd0, waiting_Led}, 32'd1);
        flag_In = 1'b0;
        tick();
        check("abort_stall", {31'd0, stall}, 32'd0);
        check("abort_led_off", {31'd0, waiting_Led}, 32'd0);
        check("abort_data_kept", data_In, 32'h0000003C);
        p0 = pulses;
        confirm_Button = 1'b1;
        ticks(8);
        confirm_Button = 1'b0;
        ticks(8);
        check("abort_no_ready", pulses, p0);

        // Reset asserted while waiting for a press.
        flag_In = 1'b1;
        ticks(3);
        confirm_Button = 1'b1;
        ticks(2);
        #3 flag_Reset = 1'b0;
        #1;
        check("rstw_data", data_In, 32'h0);
        check("rstw_ready", {31'd0, in_Ready}, 32'd0);
        check("rstw_stall", {31'd0, stall}, 32'd1);
        check("rstw_led", {31'd0, waiting_Led}, 32'd0);
        flag_In        = 1'b0;
        confirm_Button = 1'b0;
        ticks(2);
        flag_Reset = 1'b1;
        ticks(10);
        check("rstw_no_ready", pulses, p0);
        check("rstw_data_after", data_In, 32'h0);

        check("scoreboard_empty", exp_q.size(), 0);
        check("pulse_total", pulses, 9);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
